uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit (even, or odd when PARITY_ODD=1).
module uart_tx_param #(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              Tx,
    output logic [2:0]        dbg_state
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    generate
        if (DATA_W < 5 || DATA_W > 9 || CLK_DIV < 2 ||
            (STOP_BITS != 1 && STOP_BITS != 2) ||
            (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
            $error("uart_tx_param: illegal parameter combination");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
    logic                baud_last;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = data_in;
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
                    // Parity accumulates from the latched bits as they leave.
                    par_d   = par_q ^ shift_q[0];
`endif
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so Tx stays a pure register.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign ready     = (state_q == IDLE);
    assign busy      = ~ready;
    assign done      = done_q;
    assign Tx        = tx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: table of frames plus hand-written back-to-back, busy-start,
// mid-frame reset and 7-bit/2-stop sequences.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int DIV_A = 4;
    localparam int DIV_B = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a_data;
    logic       a_start;
    logic       a_ready, a_busy, a_done, a_tx;
    logic [2:0] a_dbg;
    logic [6:0] b_data;
    logic       b_start;
    logic       b_ready, b_busy, b_done, b_tx;
    logic [2:0] b_dbg;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_W(8), .CLK_DIV(DIV_A), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
        .clk(clk), .reset(reset), .data_in(a_data), .start(a_start),
        .ready(a_ready), .busy(a_busy), .done(a_done), .Tx(a_tx), .dbg_state(a_dbg)
    );

    uart_tx_param #(.DATA_W(7), .CLK_DIV(DIV_B), .STOP_BITS(2), .PARITY_ODD(0)) u_b (
        .clk(clk), .reset(reset), .data_in(b_data), .start(b_start),
        .ready(b_ready), .busy(b_busy), .done(b_done), .Tx(b_tx), .dbg_state(b_dbg)
    );

`ifdef UART_TX_PARITY_EN
    logic       c_ready, c_busy, c_done, c_tx;
    logic [2:0] c_dbg;
    uart_tx_param #(.DATA_W(8), .CLK_DIV(DIV_A), .STOP_BITS(1), .PARITY_ODD(1)) u_c (
        .clk(clk), .reset(reset), .data_in(a_data), .start(a_start),
        .ready(c_ready), .busy(c_busy), .done(c_done), .Tx(c_tx), .dbg_state(c_dbg)
    );
`endif

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;   // send order, bit 9 first: start, 8 data LSB first, stop
        logic       par;    // even parity of data
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_start(input logic [7:0] d);
        a_start = 1'b1;
        a_data  = d;
        next_cycle();
        a_start = 1'b0;
        a_data  = ~d;
    endtask

    // Checks every cycle of an instance-A frame; returns at the negedge of the done cycle.
    task automatic check_frame(input string name, input logic [9:0] bits, input logic par,
                               input int inject_at);
        logic seq[11];
        int   nbits;
        int   n;
        logic bit_bad;
        logic ctl_bad;
        logic c_bad;
        nbits = 0;
        for (int j = 9; j >= 1; j--) begin
            seq[nbits] = bits[j];
            nbits++;
        end
        if (P == 1) begin
            seq[nbits] = par;
            nbits++;
        end
        seq[nbits] = bits[0];
        nbits++;
        n       = nbits * DIV_A;
        bit_bad = 1'b0;
        ctl_bad = 1'b0;
        c_bad   = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == inject_at) begin
                a_start = 1'b1;
                a_data  = 8'hFF;
            end else if (i == inject_at + 1) begin
                a_start = 1'b0;
                a_data  = 8'h00;
            end
            if (a_tx !== seq[i / DIV_A]) bit_bad = 1'b1;
            if (a_ready !== 1'b0 || a_busy !== 1'b1 || a_done !== 1'b0) ctl_bad = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (c_tx !== ((i / DIV_A == 9) ? ~seq[i / DIV_A] : seq[i / DIV_A])) c_bad = 1'b1;
`endif
            if (i % DIV_A == DIV_A - 1) begin
                chk($sformatf("%s bit%0d tx", name, i / DIV_A), {31'd0, bit_bad}, 32'd0);
                bit_bad = 1'b0;
            end
            if (i < n - 1) next_cycle();
        end
        chk($sformatf("%s busy/ready/done in frame", name), {31'd0, ctl_bad}, 32'd0);
        if (P == 1) chk($sformatf("%s odd parity frame", name), {31'd0, c_bad}, 32'd0);
        next_cycle();
        chk($sformatf("%s done pulse", name), {31'd0, a_done}, 32'd1);
        chk($sformatf("%s ready at done", name), {31'd0, a_ready}, 32'd1);
        chk($sformatf("%s tx idle at done", name), {31'd0, a_tx}, 32'd1);
    endtask

    initial begin
        logic b_seq[11];
        int   nb;
        logic b_bad;

        vecs[0] = '{8'hA5, 10'b0_10100101_1, 1'b0};
        vecs[1] = '{8'h00, 10'b0_00000000_1, 1'b0};
        vecs[2] = '{8'hFF, 10'b0_11111111_1, 1'b0};
        vecs[3] = '{8'h01, 10'b0_10000000_1, 1'b1};
        vecs[4] = '{8'h80, 10'b0_00000001_1, 1'b1};
        vecs[5] = '{8'h3C, 10'b0_00111100_1, 1'b0};
        vecs[6] = '{8'h81, 10'b0_10000001_1, 1'b0};
        vecs[7] = '{8'h6B, 10'b0_11010110_1, 1'b1};

        reset   = 1'b1;
        a_data  = 8'h00;
        a_start = 1'b0;
        b_data  = 7'h00;
        b_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset tx", {31'd0, a_tx}, 32'd1);
        chk("reset ready", {31'd0, a_ready}, 32'd1);
        chk("reset busy", {31'd0, a_busy}, 32'd0);
        chk("reset done", {31'd0, a_done}, 32'd0);
        chk("reset state", {29'd0, a_dbg}, 32'd0);
        chk("reset b tx", {31'd0, b_tx}, 32'd1);

        // First start on the first edge after reset release.
        reset = 1'b0;
        for (int v = 0; v < 8; v++) begin
            send_start(vecs[v].data);
            check_frame($sformatf("vec%0d", v), vecs[v].bits, vecs[v].par, -1);
            next_cycle();
            chk($sformatf("vec%0d done one cycle", v), {31'd0, a_done}, 32'd0);
            chk($sformatf("vec%0d idle state", v), {29'd0, a_dbg}, 32'd0);
        end

        // Back-to-back: start asserted in the done cycle.
        send_start(8'hA5);
        check_frame("b2b first", 10'b0_10100101_1, 1'b0, -1);
        send_start(8'h3C);
        check_frame("b2b second", 10'b0_00111100_1, 1'b0, -1);
        next_cycle();
        chk("b2b done low", {31'd0, a_done}, 32'd0);

        // Start with different data while busy is ignored.
        next_cycle();
        send_start(8'hA5);
        check_frame("busy start", 10'b0_10100101_1, 1'b0, 10);
        next_cycle();
        chk("busy start no extra done", {31'd0, a_done}, 32'd0);
        next_cycle();
        chk("busy start not queued", {31'd0, a_ready}, 32'd1);

        // Mid-frame reset.
        send_start(8'h00);
        repeat (15) next_cycle();
        chk("pre-reset tx low", {31'd0, a_tx}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("async reset tx", {31'd0, a_tx}, 32'd1);
        chk("async reset ready", {31'd0, a_ready}, 32'd1);
        chk("async reset busy", {31'd0, a_busy}, 32'd0);
        chk("async reset state", {29'd0, a_dbg}, 32'd0);
        b_bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (a_done !== 1'b0) b_bad = 1'b1;
        end
        reset = 1'b0;
        repeat (3) begin
            if (a_done !== 1'b0) b_bad = 1'b1;
            next_cycle();
        end
        chk("no done after abort", {31'd0, b_bad}, 32'd0);
        send_start(8'h81);
        check_frame("after reset 0x81", 10'b0_10000001_1, 1'b0, -1);
        next_cycle();

        // 7 data bits, 2 stop bits, CLK_DIV=3 on instance B.
        nb = 0;
        b_seq[nb] = 1'b0; nb++;
        for (int j = 0; j < 7; j++) begin
            b_seq[nb] = (j % 2 == 0); nb++;
        end
        if (P == 1) begin
            b_seq[nb] = 1'b0; nb++;
        end
        b_seq[nb] = 1'b1; nb++;
        b_seq[nb] = 1'b1; nb++;
        b_start = 1'b1;
        b_data  = 7'h55;
        next_cycle();
        b_start = 1'b0;
        b_data  = 7'h2A;
        b_bad   = 1'b0;
        for (int i = 0; i < nb * DIV_B; i++) begin
            if (b_tx !== b_seq[i / DIV_B]) b_bad = 1'b1;
            if (b_done !== 1'b0 || b_busy !== 1'b1) b_bad = 1'b1;
            if (i % DIV_B == DIV_B - 1) begin
                chk($sformatf("b bit%0d", i / DIV_B), {31'd0, b_bad}, 32'd0);
                b_bad = 1'b0;
            end
            if (i < nb * DIV_B - 1) next_cycle();
        end
        next_cycle();
        chk("b done after 30 cycles", {31'd0, b_done}, 32'd1);
        chk("b ready at done", {31'd0, b_ready}, 32'd1);
        next_cycle();
        chk("b done one cycle", {31'd0, b_done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
